writeback_queue: RTL and testbench

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue.sv | 104 ++++++++++
 tb/tb_writeback_queue.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// Register-bank writeback FIFO with youngest-match read forwarding; push visible next cycle, drain one entry per cycle.
// in_ready drops only when all DEPTH entries are live; register-0 writes are acknowledged but dropped.
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_dir,
    input  logic [31:0] in_data,
    input  logic        drain_en,
    output logic        RegWrite,
    output logic [4:0]  Dir,
    output logic [31:0] Di,
    input  logic [4:0]  RA1,
    input  logic [4:0]  RA2,
    output logic        fwd1_hit,
    output logic        fwd2_hit,
    output logic [31:0] fwd1_data,
    output logic [31:0] fwd2_data,
    output logic [2:0]  count
);

    localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    typedef struct packed {
        logic [4:0]  dir;
        logic [31:0] data;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [DEPTH-1:0]  vld;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic              push;
    logic              pop;

    // Readiness looks only at stored occupancy, so a pop never frees a slot in the same cycle.
    assign in_ready = (count < DEPTH_C);
    assign pop      = drain_en && (count != 3'd0);
    assign push     = in_valid && in_ready && (in_dir != 5'd0);

    assign RegWrite = pop;
    assign Dir      = (count != 3'd0) ? mem[head].dir  : 5'd0;
    assign Di       = (count != 3'd0) ? mem[head].data : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= 3'd0;
            vld   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[tail] <= '{dir: in_dir, data: in_data};
                vld[tail] <= 1'b1;
                tail      <= tail + PW'(1);
            end
            if (pop) begin
                vld[head] <= 1'b0;
                head      <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Scan oldest to youngest so the last match seen is the youngest live write.
    for (genvar p = 0; p < 2; p++) begin : g_fwd
        logic [4:0]    ra;
        logic          hit;
        logic [31:0]   dat;
        logic [PW-1:0] idx;

        assign ra = (p == 0) ? RA1 : RA2;

        always_comb begin
            hit = 1'b0;
            dat = 32'd0;
            idx = '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx = head + PW'(i);
                if (vld[idx] && (ra != 5'd0) && (mem[idx].dir == ra)) begin
                    hit = 1'b1;
                    dat = mem[idx].data;
                end
            end
        end
    end

    assign fwd1_hit  = g_fwd[0].hit;
    assign fwd1_data = g_fwd[0].dat;
    assign fwd2_hit  = g_fwd[1].hit;
    assign fwd2_data = g_fwd[1].dat;

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: queue-based reference model checked every cycle plus literal spot checks.
module tb_writeback_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_dir;
    logic [31:0] in_data;
    logic        drain_en;
    logic        RegWrite;
    logic [4:0]  Dir;
    logic [31:0] Di;
    logic [4:0]  RA1;
    logic [4:0]  RA2;
    logic        fwd1_hit;
    logic        fwd2_hit;
    logic [31:0] fwd1_data;
    logic [31:0] fwd2_data;
    logic [2:0]  count;

    always #5 clk = ~clk;

    writeback_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_dir(in_dir), .in_data(in_data),
        .drain_en(drain_en), .RegWrite(RegWrite), .Dir(Dir), .Di(Di),
        .RA1(RA1), .RA2(RA2),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
        .count(count)
    );

    int tests = 0;
    int fails = 0;

    logic [36:0] mq[$];       // reference contents, oldest first: {dir, data}
    logic [36:0] dut_log[$];  // writes the register bank actually received
    logic [36:0] exp_log[$];  // hand-computed bank write sequence

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        int          n;
        logic        h1, h2;
        logic [31:0] d1, d2;
        logic [36:0] hd;
        n  = mq.size();
        h1 = 1'b0; h2 = 1'b0; d1 = 32'd0; d2 = 32'd0;
        hd = (n > 0) ? mq[0] : 37'd0;
        foreach (mq[i]) begin
            if (RA1 != 5'd0 && mq[i][36:32] == RA1) begin h1 = 1'b1; d1 = mq[i][31:0]; end
            if (RA2 != 5'd0 && mq[i][36:32] == RA2) begin h2 = 1'b1; d2 = mq[i][31:0]; end
        end
        chk("model_in_ready",  32'(in_ready),  32'(n < 4));
        chk("model_count",     32'(count),     32'(n));
        chk("model_regwrite",  32'(RegWrite),  32'(drain_en && n > 0));
        chk("model_dir",       32'(Dir),       32'(hd[36:32]));
        chk("model_di",        Di,             hd[31:0]);
        chk("model_fwd1_hit",  32'(fwd1_hit),  32'(h1));
        chk("model_fwd1_data", fwd1_data,      d1);
        chk("model_fwd2_hit",  32'(fwd2_hit),  32'(h2));
        chk("model_fwd2_data", fwd2_data,      d2);
        chk("model_no_r0_write", 32'(RegWrite && Dir == 5'd0), 32'd0);
        if (RegWrite) dut_log.push_back({Dir, Di});
    endtask

    task automatic model_update();
        logic do_pop, do_push;
        if (!rst_n) begin
            mq.delete();
            return;
        end
        do_pop  = drain_en && (mq.size() > 0);
        do_push = in_valid && (mq.size() < 4) && (in_dir != 5'd0);
        if (do_pop)  void'(mq.pop_front());
        if (do_push) mq.push_back({in_dir, in_data});
    endtask

    // Inputs change at posedge+1, outputs are compared at negedge, model advances at posedge.
    task automatic cycle();
        @(negedge clk);
        compare_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_dir = 5'd0; in_data = 32'd0;
        drain_en = 1'b0; RA1 = 5'd0; RA2 = 5'd0;
        cycle(); cycle();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_count",    32'(count),    32'd0);
        chk("rst_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_dir",      32'(Dir),      32'd0);
        chk("rst_di",       Di,            32'd0);
        rst_n = 1'b1;
        cycle();

        // single push, forwarded, not drained
        in_valid = 1'b1; in_dir = 5'd5; in_data = 32'h1111_1111; RA1 = 5'd5;
        cycle();
        in_valid = 1'b0; #1;
        chk("p1_fwd1_hit",  32'(fwd1_hit), 32'd1);
        chk("p1_fwd1_data", fwd1_data,     32'h1111_1111);
        chk("p1_count",     32'(count),    32'd1);
        chk("p1_regwrite",  32'(RegWrite), 32'd0);
        drain_en = 1'b1;
        cycle();
        drain_en = 1'b0; #1;
        chk("p1_drained_count", 32'(count), 32'd0);
        exp_log.push_back({5'd5, 32'h1111_1111});

        // duplicate destination: youngest forwarded, both written in order
        in_valid = 1'b1; in_dir = 5'd7; in_data = 32'hAAAA_0001;
        cycle();
        in_data = 32'hBBBB_0002;
        cycle();
        in_valid = 1'b0; RA2 = 5'd7; #1;
        chk("dup_fwd2_hit",  32'(fwd2_hit), 32'd1);
        chk("dup_fwd2_data", fwd2_data,     32'hBBBB_0002);
        drain_en = 1'b1;
        cycle();
        #1;
        chk("dup_second_dir", 32'(Dir),      32'd7);
        chk("dup_second_di",  Di,            32'hBBBB_0002);
        chk("dup_second_we",  32'(RegWrite), 32'd1);
        cycle();
        drain_en = 1'b0;
        exp_log.push_back({5'd7, 32'hAAAA_0001});
        exp_log.push_back({5'd7, 32'hBBBB_0002});

        // fill to full, hold a fifth request, free one slot
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_dir = 5'(i); in_data = 32'h100 + 32'(i);
            cycle();
        end
        in_dir = 5'd9; in_data = 32'h999; #1;
        chk("full_count",    32'(count),    32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        cycle();
        chk("full_held_count", 32'(count), 32'd4);
        drain_en = 1'b1; #1;
        chk("full_pop_in_ready", 32'(in_ready), 32'd0);
        cycle();
        drain_en = 1'b0; #1;
        chk("after_pop_in_ready", 32'(in_ready), 32'd1);
        chk("after_pop_count",    32'(count),    32'd3);
        cycle();
        in_valid = 1'b0; #1;
        chk("fifth_accepted_count", 32'(count), 32'd4);
        drain_en = 1'b1;
        repeat (4) cycle();
        drain_en = 1'b0;
        for (int i = 1; i <= 4; i++) exp_log.push_back({5'(i), 32'h100 + 32'(i)});
        exp_log.push_back({5'd9, 32'h999});

        // register-0 requests are consumed but never stored
        in_valid = 1'b1; in_dir = 5'd0; in_data = 32'hDEAD_BEEF; RA1 = 5'd0; #1;
        chk("r0_in_ready", 32'(in_ready), 32'd1);
        cycle();
        in_valid = 1'b0; #1;
        chk("r0_count",    32'(count),    32'd0);
        chk("r0_fwd1_hit", 32'(fwd1_hit), 32'd0);
        in_valid = 1'b1; in_dir = 5'd3; in_data = 32'h333;
        cycle();
        in_dir = 5'd0; in_data = 32'hDEAD_BEEF;
        cycle();
        in_valid = 1'b0; #1;
        chk("r0b_count",    32'(count),    32'd1);
        chk("r0b_fwd1_hit", 32'(fwd1_hit), 32'd0);
        RA1 = 5'd3; #1;
        chk("r0b_fwd_r3",   fwd1_data,     32'h333);
        drain_en = 1'b1;
        cycle();
        drain_en = 1'b0;
        exp_log.push_back({5'd3, 32'h333});

        // streaming push + drain across pointer wrap
        drain_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; in_dir = 5'(k + 1); in_data = 32'hC000_0000 + 32'(k);
            cycle();
            chk("stream_count", 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        cycle();
        drain_en = 1'b0; #1;
        chk("stream_empty", 32'(count), 32'd0);
        for (int k = 0; k < 10; k++) exp_log.push_back({5'(k + 1), 32'hC000_0000 + 32'(k)});

        // asynchronous reset discards pending writes
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_dir = 5'(11 + i); in_data = 32'hA1 + 32'(i);
            cycle();
        end
        in_valid = 1'b0; RA1 = 5'd12; RA2 = 5'd13; #1;
        chk("pre_rst_count", 32'(count),    32'd3);
        chk("pre_rst_fwd1",  32'(fwd1_hit), 32'd1);
        drain_en = 1'b1;
        rst_n = 1'b0;
        mq.delete();
        #1;
        chk("arst_count",    32'(count),    32'd0);
        chk("arst_regwrite", 32'(RegWrite), 32'd0);
        chk("arst_fwd1_hit", 32'(fwd1_hit), 32'd0);
        chk("arst_fwd2_hit", 32'(fwd2_hit), 32'd0);
        chk("arst_fwd1_data", fwd1_data,    32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_di",       Di,            32'd0);
        cycle();
        rst_n = 1'b1;
        repeat (3) cycle();
        drain_en = 1'b0;

        chk("bank_write_total", 32'(dut_log.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < dut_log.size(); i++) begin
            chk("bank_write_dir",  32'(dut_log[i][36:32]), 32'(exp_log[i][36:32]));
            chk("bank_write_data", dut_log[i][31:0],       exp_log[i][31:0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
